// File: rtl/mic_array_xcorr_lag.sv
// N-channel frame cross-correlator: estimates per-channel lag versus reference channel 0 with one serial MAC.
// Optional build macro: MIC_XCORR_SIGNED_PEAK_EN selects the signed peak metric instead of |acc|.
module mic_array_xcorr_lag #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned DW     = 16,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned LAGNUM = 16,
    parameter int unsigned ACCW   = 40,
    parameter int unsigned LAGW   = 6
) (
    input  logic                     clk_60MHz,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic                     i_smp_valid,
    input  logic [NCH*DW-1:0]        i_smp_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [(NCH-1)*LAGW-1:0]  o_lag_out
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CHW     = $clog2(NCH);
    localparam int unsigned NW      = AW + 2;
    localparam int unsigned MW      = ((AW > LAGW) ? AW : LAGW) + 2;
    localparam int unsigned PW      = 2 * DW;
    localparam int unsigned CMP_CYC = DEPTH + 2;

    localparam logic [LAGW-1:0] LAG_MIN = ~LAGW'(LAGNUM) + LAGW'(1);
    localparam logic [LAGW-1:0] LAG_MAX = LAGW'(LAGNUM);
`ifdef MIC_XCORR_SIGNED_PEAK_EN
    localparam logic [ACCW-1:0] BEST_INIT = {1'b1, {(ACCW-1){1'b0}}};
`else
    localparam logic [ACCW-1:0] BEST_INIT = '0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_CALC, S_DONE} state_t;

    state_t                  r_state, w_state_nxt;
    logic [AW-1:0]           r_wr_cnt;
    logic [CHW-1:0]          r_ch;
    logic [LAGW-1:0]         r_lag;
    logic [NW-1:0]           r_n;
    logic                    r_v1;
    logic [DW-1:0]           r_x0, r_xk;
    logic [PW-1:0]           r_prod;
    logic [ACCW-1:0]         r_acc;
    logic [ACCW-1:0]         r_best [NCH];
    logic [LAGW-1:0]         r_lagreg [NCH];
    logic [DW-1:0]           r_mem [NCH][DEPTH];

    logic [ACCW-1:0]         w_best_nxt [NCH];
    logic [LAGW-1:0]         w_lagreg_nxt [NCH];
    logic [(NCH-1)*LAGW-1:0] w_lag_out_nxt;
    logic                    w_done_nxt;
    logic [MW-1:0]           w_m;
    logic                    w_issue, w_inrange, w_cmp, w_better;
    logic                    w_last_lag, w_last_ch, w_wr;
    logic [ACCW-1:0]         w_metric;
    logic [PW-1:0]           w_prod;

    // Partner sample index n+lag; out-of-frame terms are masked to zero
    assign w_m        = MW'(r_n) + {{(MW-LAGW){r_lag[LAGW-1]}}, r_lag};
    assign w_inrange  = !w_m[MW-1] && (w_m < MW'(DEPTH));
    assign w_issue    = (r_state == S_CALC) && (r_n < NW'(DEPTH));
    assign w_cmp      = (r_state == S_CALC) && (r_n == NW'(CMP_CYC));
    assign w_last_lag = (r_lag == LAG_MAX);
    assign w_last_ch  = (r_ch == CHW'(NCH-1));
    assign w_wr       = (r_state == S_CAPTURE) && i_smp_valid;
    assign w_prod     = PW'($signed(r_x0)) * PW'($signed(r_xk));

`ifdef MIC_XCORR_SIGNED_PEAK_EN
    assign w_metric = r_acc;
    assign w_better = $signed(w_metric) >= $signed(r_best[r_ch]);
`else
    assign w_metric = r_acc[ACCW-1] ? (~r_acc + ACCW'(1)) : r_acc;
    assign w_better = w_metric >= r_best[r_ch];
`endif

    // Next-state, peak tracking and output staging
    always_comb begin
        w_state_nxt   = r_state;
        w_best_nxt    = r_best;
        w_lagreg_nxt  = r_lagreg;
        w_lag_out_nxt = o_lag_out;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_CAPTURE;
                    for (int k = 0; k < NCH; k++) begin
                        w_best_nxt[k]   = BEST_INIT;
                        w_lagreg_nxt[k] = '0;
                    end
                end
            end
            S_CAPTURE: begin
                if (i_smp_valid && (r_wr_cnt == AW'(DEPTH-1))) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (w_cmp) begin
                    if (w_better) begin
                        w_best_nxt[r_ch]   = w_metric;
                        w_lagreg_nxt[r_ch] = r_lag;
                    end
                    if (w_last_lag && w_last_ch) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        for (int k = 1; k < NCH; k++) begin
                            w_lag_out_nxt[(k-1)*LAGW +: LAGW] = w_lagreg_nxt[k];
                        end
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_lag_out <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_best[k]   <= '0;
                r_lagreg[k] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            o_busy    <= (w_state_nxt != S_IDLE);
            o_done    <= w_done_nxt;
            o_lag_out <= w_lag_out_nxt;
            r_best    <= w_best_nxt;
            r_lagreg  <= w_lagreg_nxt;
        end
    end

    // Counters and MAC pipeline: read -> multiply -> accumulate, one lag drained before the next
    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt <= '0;
            r_ch     <= CHW'(1);
            r_lag    <= LAG_MIN;
            r_n      <= '0;
            r_v1     <= 1'b0;
            r_prod   <= '0;
            r_acc    <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_wr_cnt <= '0;
                r_ch     <= CHW'(1);
                r_lag    <= LAG_MIN;
                r_n      <= '0;
            end else if (w_wr) begin
                r_wr_cnt <= r_wr_cnt + AW'(1);
            end else if (r_state == S_CALC) begin
                if (w_cmp) begin
                    r_n <= '0;
                    if (w_last_lag) begin
                        r_lag <= LAG_MIN;
                        r_ch  <= r_ch + CHW'(1);
                    end else begin
                        r_lag <= r_lag + LAGW'(1);
                    end
                end else begin
                    r_n <= r_n + NW'(1);
                end
            end
            r_v1   <= w_issue && w_inrange;
            r_prod <= r_v1 ? w_prod : '0;
            if ((r_state != S_CALC) || w_cmp) begin
                r_acc <= '0;
            end else begin
                r_acc <= r_acc + {{(ACCW-PW){r_prod[PW-1]}}, r_prod};
            end
        end
    end

    // Sample RAM: one write of every channel per accepted sample, two synchronous reads
    always_ff @(posedge clk_60MHz) begin
        if (w_wr) begin
            for (int k = 0; k < NCH; k++) begin
                r_mem[k][r_wr_cnt] <= i_smp_data[k*DW +: DW];
            end
        end
        r_x0 <= r_mem[0][r_n[AW-1:0]];
        r_xk <= r_mem[r_ch][w_m[AW-1:0]];
    end

endmodule
